// File: rtl/mam_wb_sram.sv
// mam_wb_sram: Wishbone B3 slave SRAM with classic cycles and registered-feedback
// incrementing bursts (linear, wrap-4/8/16), byte lane writes and an error
// response for accesses outside [BASE_ADDR, BASE_ADDR + MEM_WORDS words).
module mam_wb_sram #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            MEM_WORDS  = 1024
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [ADDR_WIDTH-1:0]   ADR_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  input  logic [DATA_WIDTH/8-1:0] SEL_I,
  input  logic [2:0]              CTI_I,
  input  logic [1:0]              BTE_I,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic [DATA_WIDTH-1:0]   DAT_O
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS  = $clog2(SEL_WIDTH);
  localparam int unsigned IDX_WIDTH = $clog2(MEM_WORDS);
  localparam int unsigned NXT_WIDTH = IDX_WIDTH + 1;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLASSIC = 2'd1,
    S_BURST   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   oor_q, oor_d;
  logic [IDX_WIDTH-1:0]   baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;

  logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];

  logic                   borrow_c;
  logic [ADDR_WIDTH-1:0]  off_c;
  logic [ADDR_WIDTH-1:0]  word_c;
  logic                   in_range_c;
  logic [IDX_WIDTH-1:0]   idx_c;
  logic                   req_c;
  logic                   beat_c;
  logic                   wr_beat_c;
  logic [NXT_WIDTH-1:0]   nxt_c;
  logic [IDX_WIDTH-1:0]   nxt_idx_c;

  // Next burst word index; the extra MSB flags a linear burst running off the end.
  function automatic logic [NXT_WIDTH-1:0] next_addr(input logic [IDX_WIDTH-1:0] a,
                                                     input logic [1:0]           bte);
    logic [IDX_WIDTH-1:0] mask;
    logic [IDX_WIDTH-1:0] inc;
    case (bte)
      2'b01:   mask = IDX_WIDTH'(3);
      2'b10:   mask = IDX_WIDTH'(7);
      2'b11:   mask = IDX_WIDTH'(15);
      default: mask = '0;
    endcase
    inc = a + IDX_WIDTH'(1);
    if (bte == 2'b00) begin
      return NXT_WIDTH'(a) + NXT_WIDTH'(1);
    end
    return {1'b0, (a & ~mask) | (inc & mask)};
  endfunction

  // Overlay the enabled byte lanes of new_v onto old_v.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [SEL_WIDTH-1:0]  sel);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(SEL_WIDTH); i++) begin
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Byte address to word index decode; a borrow means the address is below BASE_ADDR.
  assign {borrow_c, off_c} = {1'b0, ADR_I} - {1'b0, BASE_ADDR};
  assign word_c            = off_c >> OFF_BITS;
  assign in_range_c        = !borrow_c && (word_c < ADDR_WIDTH'(MEM_WORDS));
  assign idx_c             = word_c[IDX_WIDTH-1:0];

  // Beat qualification: a response is pending and the master still requests.
  assign req_c     = CYC_I & STB_I;
  assign beat_c    = req_c & (ack_q | err_q);
  assign wr_beat_c = req_c & ack_q & WE_I;

  assign nxt_c     = next_addr(baddr_q, BTE_I);
  assign nxt_idx_c = nxt_c[IDX_WIDTH-1:0];

  // Memory array: enabled byte lanes written on acked write beats; never reset.
  always_ff @(posedge CLK_I) begin
    for (int i = 0; i < int'(SEL_WIDTH); i++) begin
      if (wr_beat_c && SEL_I[i]) mem[baddr_q][i*8 +: 8] <= DAT_I[i*8 +: 8];
    end
  end

  // Next-state, response and read-data prefetch logic.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    oor_d   = oor_q;
    baddr_d = baddr_q;
    dat_d   = dat_q;

    case (state_q)
      S_IDLE: begin
        oor_d = 1'b0;
        if (req_c) begin
          if (in_range_c) begin
            ack_d   = 1'b1;
            baddr_d = idx_c;
            dat_d   = mem[idx_c];
            state_d = (CTI_I == CTI_INCR) ? S_BURST : S_CLASSIC;
          end else begin
            err_d   = 1'b1;
            state_d = S_CLASSIC;
          end
        end
      end

      // Single response cycle, then a mandatory idle cycle before the next request.
      S_CLASSIC: begin
        state_d = S_IDLE;
      end

      S_BURST: begin
        if (!CYC_I) begin
          state_d = S_IDLE;
        end else if (beat_c && (err_q || (CTI_I == CTI_EOB))) begin
          state_d = S_IDLE;
        end else begin
          if (beat_c) begin
            if (nxt_c[IDX_WIDTH]) begin
              oor_d = 1'b1;
            end else begin
              baddr_d = nxt_idx_c;
              if (wr_beat_c && (nxt_idx_c == baddr_q)) begin
                dat_d = lane_merge(mem[nxt_idx_c], DAT_I, SEL_I);
              end else begin
                dat_d = mem[nxt_idx_c];
              end
            end
          end
          if (STB_I) begin
            if (oor_d) err_d = 1'b1;
            else       ack_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any cycle in flight.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      baddr_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
      baddr_q <= baddr_d;
      dat_q   <= dat_d;
    end
  end

  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = dat_q;

endmodule

// File: tb/tb_mam_wb_sram.sv
// tb_mam_wb_sram: directed bench for mam_wb_sram with hand-computed expectations.
module tb_mam_wb_sram;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [1:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack, err;
  logic [DW-1:0] dat_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] wbuf [16];
  logic [DW-1:0] rbuf [16];
  logic          abuf [16];
  logic          ebuf [16];
  logic [1:0]    post_resp;

  always #5 clk = ~clk;

  mam_wb_sram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  ('0),
    .MEM_WORDS  (MW)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .CYC_I (cyc),
    .STB_I (stb),
    .WE_I  (we),
    .ADR_I (adr),
    .DAT_I (dat_w),
    .SEL_I (sel),
    .CTI_I (cti),
    .BTE_I (bte),
    .ACK_O (ack),
    .ERR_O (err),
    .DAT_O (dat_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    sel = 2'b00; cti = 3'b000; bte = 2'b00;
  endtask

  // One classic cycle; checks response on the first cycle and that it drops after one.
  task automatic classic(input string tag, input logic we_v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] s,
                         input logic exp_err, input logic chk_rd, input logic [DW-1:0] exp_rd);
    cyc = 1'b1; stb = 1'b1; we = we_v; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
    tick();
    chk({tag, ".ack"}, 32'(ack), 32'(!exp_err));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    if (chk_rd) chk({tag, ".dat"}, 32'(dat_r), 32'(exp_rd));
    tick();
    chk({tag, ".drop"}, 32'({ack, err}), 32'(0));
    bus_idle();
    tick();
  endtask

  // Registered-feedback burst of n beats; ADR_I is scrambled after the first beat.
  task automatic burst(input logic we_v, input logic [AW-1:0] a, input logic [1:0] bte_v,
                       input int n);
    cyc = 1'b1; stb = 1'b1; we = we_v; adr = a; bte = bte_v; sel = 2'b11;
    cti = 3'b010; dat_w = wbuf[0];
    tick();
    adr = 32'hDEAD_BEE0;
    for (int b = 0; b < n; b++) begin
      dat_w = wbuf[b];
      cti   = (b == n - 1) ? 3'b111 : 3'b010;
      rbuf[b] = dat_r;
      abuf[b] = ack;
      ebuf[b] = err;
      tick();
    end
    post_resp = {ack, err};
    bus_idle();
    tick();
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst.ack", 32'(ack), 32'(0));
    chk("rst.err", 32'(err), 32'(0));
    chk("rst.dat", 32'(dat_r), 32'(0));
    rst = 1'b0;
    tick();

    // classic write then read of word 0
    classic("cw0", 1'b1, 32'h0, 16'h000F, 2'b11, 1'b0, 1'b0, 16'h0);
    classic("cr0", 1'b0, 32'h0, 16'h0,    2'b11, 1'b0, 1'b1, 16'h000F);

    // linear burst write words 0..3 = 1..4, then burst read back
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    burst(1'b1, 32'h0, 2'b00, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bw.ack%0d", i), 32'(abuf[i]), 32'(1));
    chk("bw.post", 32'(post_resp), 32'(0));
    burst(1'b0, 32'h0, 2'b00, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("br.ack%0d", i), 32'(abuf[i]), 32'(1));
      chk($sformatf("br.dat%0d", i), 32'(rbuf[i]), 32'(i + 1));
    end
    chk("br.post", 32'(post_resp), 32'(0));

    // words 4..7 = A4..A7, then wrap-4 read from word 6
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'hA4 + i);
    burst(1'b1, 32'h8, 2'b00, 4);
    burst(1'b0, 32'hC, 2'b01, 4);
    chk("wr.dat0", 32'(rbuf[0]), 32'h00A6);
    chk("wr.dat1", 32'(rbuf[1]), 32'h00A7);
    chk("wr.dat2", 32'(rbuf[2]), 32'h00A4);
    chk("wr.dat3", 32'(rbuf[3]), 32'h00A5);
    for (int i = 0; i < 4; i++) chk($sformatf("wr.ack%0d", i), 32'(abuf[i]), 32'(1));
    chk("wr.post", 32'(post_resp), 32'(0));

    // byte lanes on word 5
    classic("bl.w0", 1'b1, 32'hA, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0);
    classic("bl.w1", 1'b1, 32'hA, 16'h1200, 2'b10, 1'b0, 1'b0, 16'h0);
    classic("bl.r",  1'b0, 32'hA, 16'h0,    2'b11, 1'b0, 1'b1, 16'h12EF);

    // out of range classic write/read; word 0 must be untouched
    classic("oor.w", 1'b1, 32'(MW * 2), 16'h5A5A, 2'b11, 1'b1, 1'b0, 16'h0);
    classic("oor.r", 1'b0, 32'(MW * 2), 16'h0,    2'b11, 1'b1, 1'b0, 16'h0);
    classic("oor.w0", 1'b0, 32'h0,      16'h0,    2'b11, 1'b0, 1'b1, 16'h0001);

    // linear burst off the end of memory: ACK, ACK, ERR
    classic("top.w0", 1'b1, 32'((MW - 2) * 2), 16'hC0DE, 2'b11, 1'b0, 1'b0, 16'h0);
    classic("top.w1", 1'b1, 32'((MW - 1) * 2), 16'hF00D, 2'b11, 1'b0, 1'b0, 16'h0);
    burst(1'b0, 32'((MW - 2) * 2), 2'b00, 3);
    chk("top.ack0", 32'({abuf[0], ebuf[0]}), 32'h2);
    chk("top.dat0", 32'(rbuf[0]), 32'hC0DE);
    chk("top.ack1", 32'({abuf[1], ebuf[1]}), 32'h2);
    chk("top.dat1", 32'(rbuf[1]), 32'hF00D);
    chk("top.err2", 32'({abuf[2], ebuf[2]}), 32'h1);
    chk("top.post", 32'(post_resp), 32'(0));

    // stall: STB_I low for two cycles after the second beat of a 4-beat read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; bte = 2'b00; sel = 2'b11; cti = 3'b010;
    tick();
    chk("st.b0", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0001});
    tick();
    chk("st.b1", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0002});
    tick();
    stb = 1'b0;
    chk("st.b2", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0003});
    tick();
    chk("st.gap0", 32'({ack, dat_r}), {15'd0, 1'b0, 16'h0003});
    tick();
    chk("st.gap1", 32'({ack, dat_r}), {15'd0, 1'b0, 16'h0003});
    stb = 1'b1;
    tick();
    chk("st.b2again", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0003});
    tick();
    cti = 3'b111;
    chk("st.b3", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0004});
    tick();
    chk("st.post", 32'({ack, err}), 32'(0));
    bus_idle();
    tick();

    // asynchronous reset in the middle of a read burst
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; bte = 2'b00; sel = 2'b11; cti = 3'b010;
    tick();
    tick();
    chk("rb.pre", 32'({ack, dat_r}), {15'd0, 1'b1, 16'h0002});
    #2;
    rst = 1'b1;
    #1;
    chk("rb.ack", 32'(ack), 32'(0));
    chk("rb.dat", 32'(dat_r), 32'(0));
    bus_idle();
    #1;
    rst = 1'b0;
    tick();
    chk("rb.idle", 32'({ack, err}), 32'(0));
    classic("rb.fresh", 1'b0, 32'h4, 16'h0, 2'b11, 1'b0, 1'b1, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
